instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 2, instruction-memory read latency in clock edges (legal 1..7).
REQ-002 SHALL have parameter BR_OPCODE, default 6'b111100, instr[31:26] value decoded as an unconditional branch.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port pc_in  input  32  current address from the ProgramCounter next_instr output.
REQ-006 SHALL have port mem_en  output  1  instruction-memory read enable.
REQ-007 SHALL have port mem_addr  output  32  instruction-memory read address.
REQ-008 SHALL have port mem_dout  input  32  instruction-memory read data.
REQ-009 SHALL have port out_valid  output  1  fetched instruction available downstream.
REQ-010 SHALL have port out_ready  input  1  downstream accepts instruction.
REQ-011 SHALL have port out_instr  output  32  fetched instruction word.
REQ-012 SHALL have port out_pc  output  32  address the instruction was fetched from.
REQ-013 SHALL have port pc_advance  output  1  one-cycle pulse telling ProgramCounter to step.
REQ-014 SHALL have port isBranch  output  1  branch indication to ProgramCounter, valid with pc_advance.
REQ-015 SHALL have port jump_value  output  25  branch target field to ProgramCounter, valid with pc_advance.

Function
REQ-016 SHALL implement states FETCH, WAIT, HOLD, ADV; the cycle after rst deasserts is FETCH.
REQ-017 FETCH: mem_en=1, mem_addr=pc_in (combinational), pc_in latched into out_pc at the edge; next state WAIT.
REQ-018 WAIT: mem_en=0, mem_addr=out_pc; internal counter counts edges from 1; at MEM_LATENCY-th edge after leaving FETCH, mem_dout captured into out_instr and state -> HOLD.
REQ-019 Latency: with FETCH in cycle 0, out_valid SHALL first be 1 in cycle MEM_LATENCY+1.
REQ-020 HOLD: out_valid=1; out_instr and out_pc SHALL stay constant until out_valid&&out_ready at a rising edge.
REQ-021 out_ready while not in HOLD SHALL be ignored; no transfer occurs.
REQ-022 Handshake edge in HOLD: state -> ADV; out_valid deasserts at that edge.
REQ-023 ADV (exactly one cycle): pc_advance=1; isBranch=1 iff out_instr[31:26]==BR_OPCODE; jump_value=out_instr[24:0] if branch, else 0; next state FETCH.
REQ-024 pc_advance, isBranch, jump_value SHALL be 0 in every state other than ADV (registered, glitch-free).
REQ-025 mem_dout SHALL be sampled only at the capture edge of REQ-018; other values ignored.
REQ-026 mem_en SHALL never be asserted outside FETCH; exactly one read per instruction.
REQ-027 No address arithmetic in this block; pc_in passed through unmodified (32 bits, wraps only inside ProgramCounter).
REQ-028 Throughput with out_ready held 1: one instruction per MEM_LATENCY+3 cycles.

Reset
REQ-029 rst=1 at a rising edge SHALL force state FETCH-pending and counter=0, with out_valid, mem_en, pc_advance, isBranch=0 and out_instr, out_pc, jump_value=0, from any state.
REQ-030 rst asserted mid-WAIT or mid-HOLD SHALL discard the in-flight read; no pc_advance SHALL follow; first FETCH occurs the cycle after rst deasserts.
REQ-031 While rst=1, mem_en SHALL be 0 regardless of state.

Verification
REQ-032 Reset, pc_in=0, MEM_LATENCY=2, mem_dout=32'h00000013, out_ready=1 -> mem_en=1 cycle 0 with mem_addr=0; out_valid=1 cycle 3, out_instr=32'h13, out_pc=0; pc_advance=1, isBranch=0, jump_value=0 cycle 4; next mem_en cycle 5.
REQ-033 mem_dout=32'hF0000040 at pc_in=32'h10 -> ADV cycle isBranch=1, jump_value=25'h0000040, pc_advance=1.
REQ-034 out_ready=0 for 5 cycles in HOLD -> out_valid, out_instr, out_pc stable; mem_en=0 and pc_advance=0 throughout; ADV one cycle after out_ready rises.
REQ-035 rst pulsed for 1 cycle in WAIT -> following cycle all outputs 0; later mem_dout ignored; no pc_advance; FETCH the cycle after rst deasserts.
REQ-036 MEM_LATENCY=1 -> out_valid first 1 in cycle 2 after FETCH; out_ready=1 during cycles 0-1 causes no transfer.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: issues one memory read per instruction, waits the
// memory latency, presents the word downstream with valid/ready, then steps the PC.
module instr_fetch #(
    parameter int          MEM_LATENCY = 2,
    parameter logic [5:0]  BR_OPCODE   = 6'b111100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        pc_advance,
    output logic        isBranch,
    output logic [24:0] jump_value
);

    // Handshake: a transfer happens only on a rising edge where out_valid && out_ready;
    // out_valid is asserted only in HOLD and out_ready is ignored in every other state.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        ADV   = 2'd3
    } state_t;

    localparam logic [2:0] LAT = 3'(MEM_LATENCY);

    state_t     state;
    state_t     next_state;
    logic [2:0] cnt;
    logic       capture;
    logic       xfer;
    logic       is_br;

    always_comb begin
        next_state = state;
        capture    = 1'b0;
        xfer       = 1'b0;
        case (state)
            FETCH: next_state = WAIT;
            WAIT: begin
                // cnt holds the number of WAIT edges already seen
                if (cnt + 3'd1 == LAT) begin
                    capture    = 1'b1;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    xfer       = 1'b1;
                    next_state = ADV;
                end
            end
            ADV:     next_state = FETCH;
            default: next_state = FETCH;
        endcase
    end

    assign is_br     = (out_instr[31:26] == BR_OPCODE);
    assign mem_en    = (state == FETCH) && !rst;
    assign mem_addr  = (state == FETCH) ? pc_in : out_pc;
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            cnt        <= 3'd0;
            out_instr  <= 32'd0;
            out_pc     <= 32'd0;
            pc_advance <= 1'b0;
            isBranch   <= 1'b0;
            jump_value <= 25'd0;
        end else begin
            state <= next_state;
            if (state == WAIT) begin
                cnt <= cnt + 3'd1;
            end else begin
                cnt <= 3'd0;
            end
            if (state == FETCH) begin
                out_pc <= pc_in;
            end
            if (capture) begin
                out_instr <= mem_dout;
            end
            // Branch decode is registered so the ADV pulse outputs are glitch-free
            pc_advance <= xfer;
            isBranch   <= xfer && is_br;
            jump_value <= (xfer && is_br) ? out_instr[24:0] : 25'd0;
        end
    end

endmodule
